// File: rtl/tel_session.sv
// ---------------------------------------------------------------------------
// tel_session
//
// Telephone call session controller. One call is tracked from the ring
// through the conversation, where the two parties take turns sending
// characters, to a cost display. Each character sent adds a charge to a
// saturating accumulator. DEL (0x7F) hands the turn to the other party.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous, active-high reset
//   startCall      request: begin ringing (honoured only in IDLE)
//   answerCall     request: callee answers while ringing
//   endCallCaller  request: caller hangs up
//   endCallCallee  request: callee hangs up or rejects
//   sendCharCaller request: caller sends charSent (honoured only in CALLER)
//   sendCharCallee request: callee sends charSent (honoured only in CALLEE)
//   charSent       ASCII character that goes with a send request
//   statusMsg      8-character ASCII status, first character in [63:56]
//   sentMsg        MSG_CHARS-character message window, or the call cost
//                  as uppercase hex digits while in COST
// ---------------------------------------------------------------------------
module tel_session #(
    parameter int MSG_CHARS     = 8,
    parameter int RING_CYCLES   = 10,
    parameter int REJECT_CYCLES = 10,
    parameter int COST_CYCLES   = 10,
    parameter int LETTER_COST   = 2,
    parameter int DIGIT_COST    = 1,
    parameter int COST_WIDTH    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   startCall,
    input  logic                   answerCall,
    input  logic                   endCallCaller,
    input  logic                   endCallCallee,
    input  logic                   sendCharCaller,
    input  logic                   sendCharCallee,
    input  logic [7:0]             charSent,
    output logic [63:0]            statusMsg,
    output logic [8*MSG_CHARS-1:0] sentMsg
);

    localparam int MSG_W = 8 * MSG_CHARS;

    // The dwell counter only ever counts up to the longest timed state - 1.
    localparam int CNT_MAX_A = (RING_CYCLES > REJECT_CYCLES) ? RING_CYCLES : REJECT_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > COST_CYCLES) ? CNT_MAX_A : COST_CYCLES;
    localparam int CNT_W     = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_CYCLES - 1);
    localparam logic [CNT_W-1:0] REJECT_LAST = CNT_W'(REJECT_CYCLES - 1);
    localparam logic [CNT_W-1:0] COST_LAST   = CNT_W'(COST_CYCLES - 1);

    localparam logic [MSG_W-1:0]    SPACES     = {MSG_CHARS{8'h20}};
    localparam logic [COST_WIDTH:0] LETTER_ADD = (COST_WIDTH + 1)'(LETTER_COST);
    localparam logic [COST_WIDTH:0] DIGIT_ADD  = (COST_WIDTH + 1)'(DIGIT_COST);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RINGING,
        S_REJECTED,
        S_CALLER,
        S_CALLEE,
        S_COST
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [COST_WIDTH-1:0]   cost_q, cost_d;
    logic [MSG_W-1:0]        msg_q, msg_d;

    // -----------------------------------------------------------------------
    // Character classification and saturating cost update
    // -----------------------------------------------------------------------
    logic                  is_print;
    logic                  is_digit;
    logic                  is_del;
    logic [COST_WIDTH:0]   cost_sum;
    logic [COST_WIDTH-1:0] cost_sat;

    assign is_print = (charSent >= 8'h20) && (charSent <= 8'h7E);
    assign is_digit = (charSent >= 8'h30) && (charSent <= 8'h39);
    assign is_del   = (charSent == 8'h7F);

    // DEL is charged as a letter; a printable digit costs DIGIT_COST.
    assign cost_sum = {1'b0, cost_q} + ((is_print && is_digit) ? DIGIT_ADD : LETTER_ADD);
    // The carry out of the extended sum means the accumulator would wrap.
    assign cost_sat = cost_sum[COST_WIDTH] ? {COST_WIDTH{1'b1}} : cost_sum[COST_WIDTH-1:0];

    // -----------------------------------------------------------------------
    // Cost rendered as hex ASCII, one digit per message character
    // -----------------------------------------------------------------------
    logic [4*MSG_CHARS-1:0] cost_ext;
    logic [MSG_W-1:0]       cost_hex;

    assign cost_ext = (4 * MSG_CHARS)'(cost_q);

    generate
        for (genvar gi = 0; gi < MSG_CHARS; gi++) begin : g_hex
            logic [3:0] nib;
            assign nib = cost_ext[4*gi +: 4];
            // 0x37 + 10 = 'A', so letters need no separate table.
            assign cost_hex[8*gi +: 8] = (nib < 4'd10) ? (8'h30 + {4'b0000, nib})
                                                       : (8'h37 + {4'b0000, nib});
        end
    endgenerate

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            cost_q  <= '0;
            msg_q   <= SPACES;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cost_q  <= cost_d;
            msg_q   <= msg_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    logic own_send;

    // Only the party whose turn it is may send.
    assign own_send = (state_q == S_CALLER) ? sendCharCaller : sendCharCallee;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cost_d  = cost_q;
        msg_d   = msg_q;

        unique case (state_q)
            S_IDLE: begin
                if (startCall) begin
                    state_d = S_RINGING;
                    cnt_d   = '0;
                    cost_d  = '0;
                    msg_d   = SPACES;
                end
            end

            S_RINGING: begin
                if (endCallCaller) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (endCallCallee) begin
                    state_d = S_REJECTED;
                    cnt_d   = '0;
                end else if (answerCall) begin
                    state_d = S_CALLER;
                    cnt_d   = '0;
                end else if (cnt_q == RING_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_REJECTED: begin
                if (cnt_q == REJECT_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_CALLER, S_CALLEE: begin
                // Hanging up wins over a character sent in the same cycle.
                if (endCallCaller || endCallCallee) begin
                    state_d = S_COST;
                    cnt_d   = '0;
                end else if (own_send && is_print) begin
                    msg_d  = {msg_q[MSG_W-9:0], charSent};
                    cost_d = cost_sat;
                end else if (own_send && is_del) begin
                    msg_d   = SPACES;
                    cost_d  = cost_sat;
                    state_d = (state_q == S_CALLER) ? S_CALLEE : S_CALLER;
                end
            end

            S_COST: begin
                if (cnt_q == COST_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    // Leave a blank window behind so IDLE never shows a stale message.
                    msg_d   = SPACES;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                cost_d  = '0;
                msg_d   = SPACES;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    always_comb begin
        statusMsg = "IDLE    ";
        unique case (state_q)
            S_IDLE:     statusMsg = "IDLE    ";
            S_RINGING:  statusMsg = "RINGING ";
            S_REJECTED: statusMsg = "REJECTED";
            S_CALLER:   statusMsg = "CALLER  ";
            S_CALLEE:   statusMsg = "CALLEE  ";
            S_COST:     statusMsg = "COST    ";
            default:    statusMsg = "IDLE    ";
        endcase
    end

    assign sentMsg = (state_q == S_COST) ? cost_hex : msg_q;

endmodule

// File: tb/tb_tel_session.sv
// ---------------------------------------------------------------------------
// tb_tel_session
//
// Drives two tel_session instances from the same stimulus: one with default
// parameters and one with a 4-character window and an 8-bit cost so that
// saturation is reachable. A behavioural model per instance, keyed on the
// status text itself, predicts the outputs checked after every clock edge.
// ---------------------------------------------------------------------------
module tb_tel_session;

    localparam int RING   = 10;
    localparam int REJECT = 10;
    localparam int COSTC  = 10;
    localparam int LCOST  = 2;
    localparam int DCOST  = 1;
    localparam int MC_A = 8, CW_A = 32;
    localparam int MC_B = 4, CW_B = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic startCall = 0, answerCall = 0, endCallCaller = 0, endCallCallee = 0;
    logic sendCharCaller = 0, sendCharCallee = 0;
    logic [7:0] charSent = 8'h00;
    logic [63:0] status_a, status_b;
    logic [8*MC_A-1:0] sent_a;
    logic [8*MC_B-1:0] sent_b;

    always #5 clk = ~clk;

    tel_session #(
        .MSG_CHARS(MC_A), .RING_CYCLES(RING), .REJECT_CYCLES(REJECT), .COST_CYCLES(COSTC),
        .LETTER_COST(LCOST), .DIGIT_COST(DCOST), .COST_WIDTH(CW_A)
    ) dut_a (
        .clk(clk), .rst(rst), .startCall(startCall), .answerCall(answerCall),
        .endCallCaller(endCallCaller), .endCallCallee(endCallCallee),
        .sendCharCaller(sendCharCaller), .sendCharCallee(sendCharCallee),
        .charSent(charSent), .statusMsg(status_a), .sentMsg(sent_a)
    );

    tel_session #(
        .MSG_CHARS(MC_B), .RING_CYCLES(RING), .REJECT_CYCLES(REJECT), .COST_CYCLES(COSTC),
        .LETTER_COST(LCOST), .DIGIT_COST(DCOST), .COST_WIDTH(CW_B)
    ) dut_b (
        .clk(clk), .rst(rst), .startCall(startCall), .answerCall(answerCall),
        .endCallCaller(endCallCaller), .endCallCallee(endCallCallee),
        .sendCharCaller(sendCharCaller), .sendCharCallee(sendCharCallee),
        .charSent(charSent), .statusMsg(status_b), .sentMsg(sent_b)
    );

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    typedef struct {
        logic [63:0]     st;    // the status text is the state
        int              dwell; // cycles already spent in a timed state
        longint unsigned cost;
        logic [127:0]    msg;
    } mdl_t;

    function automatic logic [127:0] spaces(input int mc);
        logic [127:0] r = '0;
        for (int i = 0; i < mc; i++) r[8*i +: 8] = 8'h20;
        return r;
    endfunction

    function automatic mdl_t idle_model(input int mc);
        mdl_t r;
        r.st = "IDLE    "; r.dwell = 0; r.cost = 0; r.msg = spaces(mc);
        return r;
    endfunction

    function automatic mdl_t mstep(input mdl_t m, input int mc, input int cw,
                                   input logic sc, input logic an, input logic ecr,
                                   input logic ece, input logic scr, input logic sce,
                                   input logic [7:0] ch);
        mdl_t r = m;
        longint unsigned lim = (64'd1 << cw) - 1;
        longint unsigned charge;
        logic [127:0] mask = (128'd1 << (8 * mc)) - 128'd1;
        logic own;
        charge = (ch >= "0" && ch <= "9") ? DCOST : LCOST;
        if (m.st == "IDLE    ") begin
            if (sc) begin r.st = "RINGING "; r.dwell = 0; r.cost = 0; r.msg = spaces(mc); end
        end else if (m.st == "RINGING ") begin
            if (ecr) r.st = "IDLE    ";
            else if (ece) begin r.st = "REJECTED"; r.dwell = 0; end
            else if (an) r.st = "CALLER  ";
            else if (m.dwell + 1 >= RING) r.st = "IDLE    ";
            else r.dwell = m.dwell + 1;
        end else if (m.st == "REJECTED") begin
            if (m.dwell + 1 >= REJECT) r.st = "IDLE    ";
            else r.dwell = m.dwell + 1;
        end else if (m.st == "CALLER  " || m.st == "CALLEE  ") begin
            own = (m.st == "CALLER  ") ? scr : sce;
            if (ecr || ece) begin r.st = "COST    "; r.dwell = 0; end
            else if (own && ch >= 32 && ch <= 126) begin
                r.msg = ((m.msg << 8) | 128'(ch)) & mask;
                r.cost = (m.cost + charge > lim) ? lim : m.cost + charge;
            end else if (own && ch == 127) begin
                r.msg = spaces(mc);
                r.cost = (m.cost + LCOST > lim) ? lim : m.cost + LCOST;
                r.st = (m.st == "CALLER  ") ? "CALLEE  " : "CALLER  ";
            end
        end else if (m.st == "COST    ") begin
            if (m.dwell + 1 >= COSTC) begin r.st = "IDLE    "; r.msg = spaces(mc); end
            else r.dwell = m.dwell + 1;
        end
        return r;
    endfunction

    function automatic logic [127:0] mshow(input mdl_t m, input int mc);
        logic [127:0] r = '0;
        int d;
        if (m.st != "COST    ") return m.msg;
        for (int i = 0; i < mc; i++) begin
            d = int'((m.cost >> (4 * i)) & 64'hF);
            r[8*i +: 8] = (d < 10) ? 8'(48 + d) : 8'(55 + d);
        end
        return r;
    endfunction

    mdl_t ma, mb;
    initial begin
        ma = idle_model(MC_A);
        mb = idle_model(MC_B);
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ma = idle_model(MC_A);
            mb = idle_model(MC_B);
        end else begin
            ma = mstep(ma, MC_A, CW_A, startCall, answerCall, endCallCaller, endCallCallee,
                       sendCharCaller, sendCharCallee, charSent);
            mb = mstep(mb, MC_B, CW_B, startCall, answerCall, endCallCaller, endCallCallee,
                       sendCharCaller, sendCharCallee, charSent);
        end
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%h required=%h", name, $time, got, exp);
        end
    endtask

    logic [127:0] exp_a, exp_b;
    always @(posedge clk) begin
        #2;
        if (chk_en) begin
            exp_a = mshow(ma, MC_A);
            exp_b = mshow(mb, MC_B);
            check("model_status_a", 128'(status_a), 128'(ma.st));
            check("model_sent_a",   128'(sent_a),   128'(exp_a[63:0]));
            check("model_status_b", 128'(status_b), 128'(mb.st));
            check("model_sent_b",   128'(sent_b),   128'(exp_b[31:0]));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
        startCall = 0; answerCall = 0; endCallCaller = 0; endCallCallee = 0;
        sendCharCaller = 0; sendCharCallee = 0; charSent = 8'h00;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send_str(input string s, input bit caller);
        for (int i = 0; i < s.len(); i++) begin
            charSent = s[i];
            if (caller) sendCharCaller = 1; else sendCharCallee = 1;
            step();
            $display("send %s '%s' status=%s sent=%s", caller ? "caller" : "callee",
                     string'(s[i]), status_a, sent_a);
        end
    endtask

    task automatic send_ch(input logic [7:0] c, input bit caller);
        charSent = c;
        if (caller) sendCharCaller = 1; else sendCharCallee = 1;
        step();
        $display("send %s 0x%02h status=%s sent=%s", caller ? "caller" : "callee",
                 c, status_a, sent_a);
    endtask

    task automatic answered_call();
        startCall = 1; step();
        answerCall = 1; step();
    endtask

    function automatic logic [7:0] rand_char();
        int p = $urandom_range(0, 99);
        if (p < 55) return 8'($urandom_range(32, 126));
        if (p < 70) return 8'($urandom_range(48, 57));
        if (p < 82) return 8'h7F;
        return 8'($urandom_range(0, 255));
    endfunction

    task automatic random_phase(input int cycles, input int end_pm);
        for (int i = 0; i < cycles; i++) begin
            startCall      = ($urandom_range(0, 99) < 10);
            answerCall     = ($urandom_range(0, 99) < 15);
            endCallCaller  = ($urandom_range(0, 999) < end_pm);
            endCallCallee  = ($urandom_range(0, 999) < end_pm);
            sendCharCaller = ($urandom_range(0, 99) < 45);
            sendCharCallee = ($urandom_range(0, 99) < 45);
            charSent       = rand_char();
            if ($urandom_range(0, 999) < 3) begin
                rst = 1; step(); rst = 0;
                $display("random reset cycle=%0d", i);
            end else begin
                step();
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        rst = 1;
        steps(2);
        chk_en = 1;
        check("reset_status", 128'(status_a), 128'("IDLE    "));
        check("reset_sent",   128'(sent_a),   128'("        "));
        rst = 0;
        step();

        // Unanswered ring
        startCall = 1; step();
        check("ring_start", 128'(status_a), 128'("RINGING "));
        steps(9);
        check("ring_last", 128'(status_a), 128'("RINGING "));
        step();
        check("ring_timeout", 128'(status_a), 128'("IDLE    "));
        $display("unanswered ring done status=%s", status_a);

        // Reject two cycles after the ring starts
        startCall = 1; step();
        step();
        endCallCallee = 1; step();
        check("reject_enter", 128'(status_a), 128'("REJECTED"));
        steps(9);
        check("reject_last", 128'(status_a), 128'("REJECTED"));
        step();
        check("reject_done", 128'(status_a), 128'("IDLE    "));
        $display("reject done status=%s", status_a);

        // Full session
        answered_call();
        check("answered", 128'(status_a), 128'("CALLER  "));
        send_str("TERM PROJECT", 1'b1);
        check("session_pre_del", 128'(sent_a), 128'(" PROJECT"));
        send_ch(8'h7F, 1'b1);
        check("session_turn", 128'(status_a), 128'("CALLEE  "));
        send_str("CS303", 1'b0);
        check("session_pre_end", 128'(sent_a), 128'("   CS303"));
        endCallCallee = 1; step();
        check("session_cost_status", 128'(status_a), 128'("COST    "));
        check("session_cost_value",  128'(sent_a),   128'("00000021"));
        steps(9);
        check("cost_last", 128'(status_a), 128'("COST    "));
        step();
        check("cost_done", 128'(status_a), 128'("IDLE    "));

        // Bidirectional turn
        answered_call();
        send_ch(8'h7F, 1'b1);
        send_ch("X", 1'b0);
        send_ch(8'h7F, 1'b0);
        check("turn_back", 128'(status_a), 128'("CALLER  "));
        check("turn_blank", 128'(sent_a), 128'("        "));
        send_ch("Y", 1'b0);
        check("turn_ignored", 128'(sent_a), 128'("        "));
        send_ch(8'h05, 1'b1);
        endCallCaller = 1; step();
        check("turn_cost", 128'(sent_a), 128'("00000006"));
        steps(COSTC);

        // Hang-up wins over a same-cycle character
        answered_call();
        send_ch("B", 1'b1);
        endCallCaller = 1; sendCharCaller = 1; charSent = "A"; step();
        check("simul_status", 128'(status_a), 128'("COST    "));
        check("simul_cost",   128'(sent_a),   128'("00000002"));
        steps(COSTC);

        // Saturation in the narrow instance, then reset mid-COST
        answered_call();
        for (int i = 0; i < 130; i++) begin
            sendCharCaller = 1; charSent = "Q"; step();
        end
        endCallCaller = 1; step();
        check("sat_b", 128'(sent_b), 128'("00FF"));
        check("nosat_a", 128'(sent_a), 128'("00000104"));
        $display("saturation a=%s b=%s", sent_a, sent_b);
        steps(3);
        rst = 1;
        #1;
        check("midcost_rst_status", 128'(status_b), 128'("IDLE    "));
        check("midcost_rst_sent",   128'(sent_b),   128'("    "));
        step();
        rst = 0;
        step();

        // Randomised traffic: short calls, then long calls
        random_phase(3000, 30);
        random_phase(2500, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
